div_unit: RTL

Iterative radix-2 restoring divider: the responder side of the decode stage's divide handshake. Decode raises `start` while a DIV/DIVU/REM/REMU sits in ID and stalls on `start && !div_ready`. This block computes the RISC-V M-extension result and pulses `div_ready` with `divres` valid. `divres` also feeds the EX/MEM forwarding path.

---
 rtl/mini_riscv_pkg.sv | 16 +
 rtl/div_step.sv | 20 ++
 rtl/div_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/mini_riscv_pkg.sv
// mini_riscv_pkg: shared divide-unit types and constants
package mini_riscv_pkg;
  typedef enum logic [2:0] {
    DIV  = 3'b100,
    DIVU = 3'b101,
    REM  = 3'b110,
    REMU = 3'b111
  } divsel_t;
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
// ports: rem/quo/divisor in, next_rem/next_quo out
module div_step import mini_riscv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic [WIDTH-1:0] next_quo
);
  logic [WIDTH+1:0] sh;
  logic             ge;
  always_comb begin
    sh       = {rem, quo[WIDTH-1]};
    ge       = sh >= {2'b0, divisor};
    next_rem = (WIDTH+1)'(ge ? sh - {2'b0, divisor} : sh);
    next_quo = {quo[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU
// ports: clk, Rst (async active-low), hold (freeze), start/divsel/dividend/divisor in;
//        div_ready (DONE), busy (CALC/FIX), divres (registered result) out
// DIV_FASTPATH_EN: divide-by-zero and signed overflow skip CALC
module div_unit import mini_riscv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             hold,
  input  logic             start,
  input  logic [2:0]       divsel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_ready,
  output logic             busy,
  output logic [WIDTH-1:0] divres
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  div_state_t       state;
  divsel_t          op;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem, nrem;
  logic [WIDTH-1:0] quo, nquo, dvs, dvd;
  logic [WIDTH-1:0] abs_a, abs_b, qv, rv;
  logic             qneg, rneg, isrem, z, ovf, sgn, z_in, ovf_in;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .next_rem (nrem),
    .next_quo (nquo)
  );
  always_comb begin
    op        = divsel_t'(divsel);
    sgn       = op == DIV || op == REM;
    abs_a     = sgn && dividend[WIDTH-1] ? -dividend : dividend;
    abs_b     = sgn && divisor[WIDTH-1] ? -divisor : divisor;
    z_in      = divisor == '0;
    ovf_in    = sgn && dividend == MIN && divisor == '1;
    qv        = z ? '1 : ovf ? MIN : qneg ? -quo : quo;
    rv        = z ? dvd : ovf ? '0 : rneg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    div_ready = state == DONE;
    busy      = state == CALC || state == FIX;
  end
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      dvd    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      isrem  <= 1'b0;
      z      <= 1'b0;
      ovf    <= 1'b0;
      divres <= '0;
    end else if (!hold) begin
      if (state == IDLE) begin
        if (start) begin
          quo   <= abs_a;
          dvs   <= abs_b;
          dvd   <= dividend;
          rem   <= '0;
          qneg  <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg  <= sgn && dividend[WIDTH-1];
          isrem <= op == REM || op == REMU;
          z     <= z_in;
          ovf   <= ovf_in;
          cnt   <= CW'(WIDTH-1);
`ifdef DIV_FASTPATH_EN
          state <= z_in || ovf_in ? FIX : CALC;
`else
          state <= CALC;
`endif
        end
      end else if (!start && state != DONE) state <= IDLE;
      else if (state == CALC) begin
        rem   <= nrem;
        quo   <= nquo;
        cnt   <= cnt == '0 ? cnt : cnt - 1'b1;
        state <= cnt == '0 ? FIX : CALC;
      end else if (state == FIX) begin
        divres <= isrem ? rv : qv;
        state  <= DONE;
      end else state <= IDLE;
    end
endmodule
